aes_decipher_ctrl: RTL and testbench

- Control FSM that sequences the combinational AES decipher round datapath through one complete block decryption.
- Drives round_type (init/main/final), the round key index and the state-register write enables.
- Handles the start/ready/valid handshake toward the core and the key-availability stall toward key storage.
- Sits between the AES core control logic and the decipher round plus its 128-bit state register.

---
 rtl/aes_decipher_ctrl.sv | 118 +++++++++++
 tb/tb_aes_decipher_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_ctrl.sv
// Round sequencer for the AES decipher datapath: walks round keys Nr..0,
// selects the round flavour and strobes the state register once per round.
module aes_decipher_ctrl #(
    parameter int unsigned AES128_ROUNDS = 10,
    parameter int unsigned AES256_ROUNDS = 14
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       next,
    input  logic       keylen,
    input  logic       key_ready,
    output logic [3:0] round_nr,
    output logic [1:0] round_type,
    output logic       state_init,
    output logic       state_we,
    output logic       ready,
    output logic       valid
);

    localparam int unsigned RW = 4;
    localparam int unsigned TW = 2;

    localparam logic [TW-1:0] INIT_ROUND  = TW'(0);
    localparam logic [TW-1:0] MAIN_ROUND  = TW'(1);
    localparam logic [TW-1:0] FINAL_ROUND = TW'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        MAIN  = 2'd2,
        FINAL = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] round_nr_d;
    logic          ready_d;
    logic          valid_d;
    logic          keylen_q, keylen_d;
    logic [RW-1:0] nr_new;
    logic [RW-1:0] nr_cur;

    // Round count for the keylen being accepted and for the captured keylen
    assign nr_new = keylen   ? RW'(AES256_ROUNDS) : RW'(AES128_ROUNDS);
    assign nr_cur = keylen_q ? RW'(AES256_ROUNDS) : RW'(AES128_ROUNDS);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            round_nr <= '0;
            ready    <= 1'b1;
            valid    <= 1'b0;
            keylen_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_nr <= round_nr_d;
            ready    <= ready_d;
            valid    <= valid_d;
            keylen_q <= keylen_d;
        end
    end

    // Next-state logic and datapath control decode; key_ready low holds everything
    always_comb begin
        state_d    = state_q;
        round_nr_d = round_nr;
        ready_d    = ready;
        valid_d    = valid;
        keylen_d   = keylen_q;
        round_type = INIT_ROUND;
        state_init = 1'b0;
        state_we   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (next) begin
                    keylen_d   = keylen;
                    round_nr_d = nr_new;
                    valid_d    = 1'b0;
                    ready_d    = 1'b0;
                    state_d    = INIT;
                end
            end
            INIT: begin
                round_type = INIT_ROUND;
                state_init = 1'b1;
                if (key_ready) begin
                    state_we   = 1'b1;
                    round_nr_d = nr_cur - RW'(1);
                    state_d    = MAIN;
                end
            end
            MAIN: begin
                round_type = MAIN_ROUND;
                if (key_ready) begin
                    state_we   = 1'b1;
                    round_nr_d = round_nr - RW'(1);
                    if (round_nr == RW'(1)) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                round_type = FINAL_ROUND;
                if (key_ready) begin
                    state_we = 1'b1;
                    valid_d  = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_decipher_ctrl.sv
// Bench for aes_decipher_ctrl: a block-level model (busy flag, step index
// within the block, round count) predicts every output each cycle; directed
// runs pin latency and pulse counts to literal values.
module tb_aes_decipher_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       next = 1'b0;
    logic       keylen = 1'b0;
    logic       key_ready = 1'b1;
    logic [3:0] round_nr;
    logic [1:0] round_type;
    logic       state_init;
    logic       state_we;
    logic       ready;
    logic       valid;

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;

    // Model: block in progress, step k of 0..nr (0 = init, nr = final)
    bit m_busy = 1'b0;
    int m_k = 0;
    int m_nr = 10;
    bit m_valid = 1'b0;
    int e_rn;
    int e_rt;

    aes_decipher_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .next       (next),
        .keylen     (keylen),
        .key_ready  (key_ready),
        .round_nr   (round_nr),
        .round_type (round_type),
        .state_init (state_init),
        .state_we   (state_we),
        .ready      (ready),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        if (!reset_n) begin
            m_busy  = 1'b0;
            m_k     = 0;
            m_valid = 1'b0;
            chk("rst_round_nr", 32'(round_nr), 0);
            chk("rst_round_type", 32'(round_type), 0);
            chk("rst_state_init", 32'(state_init), 0);
            chk("rst_state_we", 32'(state_we), 0);
            chk("rst_ready", 32'(ready), 1);
            chk("rst_valid", 32'(valid), 0);
        end else begin
            e_rn = m_busy ? (m_nr - m_k) : 0;
            e_rt = !m_busy ? 0 : ((m_k == 0) ? 0 : ((m_k == m_nr) ? 2 : 1));
            chk("round_nr", 32'(round_nr), 32'(e_rn));
            chk("round_type", 32'(round_type), 32'(e_rt));
            chk("state_init", 32'(state_init), 32'(m_busy && m_k == 0));
            chk("state_we", 32'(state_we), 32'(m_busy && key_ready));
            chk("ready", 32'(ready), 32'(!m_busy));
            chk("valid", 32'(valid), 32'(m_valid));
            if (state_we === 1'b1) we_cnt++;
            if (!m_busy) begin
                if (next) begin
                    m_busy  = 1'b1;
                    m_k     = 0;
                    m_nr    = keylen ? 14 : 10;
                    m_valid = 1'b0;
                end
            end else if (key_ready) begin
                if (m_k == m_nr) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b1;
                end else begin
                    m_k++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a block; called #1 after an edge with ready high
    task automatic pulse_next(input logic kl);
        next      = 1'b1;
        keylen    = kl;
        key_ready = 1'b1;
        step();
        next = 1'b0;
    endtask

    // Run to completion; mode 0 plain, 1 key stalls, 2 next/keylen noise in MAIN
    task automatic wait_done(input int mode, input int exp_cyc, input int exp_we, input string name);
        int cyc = 0;
        int we0 = we_cnt;
        int s6 = 0;
        int sf = 0;
        while (cyc < 100 && valid !== 1'b1) begin
            key_ready = 1'b1;
            next      = 1'b0;
            if (mode == 1) begin
                if (round_type == 2'd1 && round_nr == 4'd6 && s6 < 3) begin
                    key_ready = 1'b0;
                    s6++;
                end else if (round_type == 2'd2 && sf < 1) begin
                    key_ready = 1'b0;
                    sf++;
                end
            end
            if (mode == 2 && round_type == 2'd1 && round_nr >= 4'd3 && round_nr <= 4'd7) begin
                next   = 1'b1;
                keylen = ~keylen;
            end
            step();
            cyc++;
        end
        key_ready = 1'b1;
        next      = 1'b0;
        chk({name, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({name, "_we_pulses"}, 32'(we_cnt - we0), 32'(exp_we));
        chk({name, "_ready_at_done"}, 32'(ready), 1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        // AES-128 then back-to-back AES-128 on first ready cycle
        pulse_next(1'b0);
        chk("a128_start_rn", 32'(round_nr), 10);
        chk("a128_state_init", 32'(state_init), 1);
        wait_done(0, 11, 11, "a128");
        pulse_next(1'b0);
        chk("b2b_valid_cleared", 32'(valid), 0);
        wait_done(0, 11, 11, "b2b");

        // AES-256
        pulse_next(1'b1);
        chk("a256_start_rn", 32'(round_nr), 14);
        wait_done(0, 15, 15, "a256");

        // Key stalls: 3 at round 6, 1 in final
        pulse_next(1'b0);
        wait_done(1, 15, 11, "stall");

        // next/keylen noise while busy, then reload with AES-256 while valid
        pulse_next(1'b0);
        wait_done(2, 11, 11, "ignore");
        pulse_next(1'b1);
        chk("reload_valid", 32'(valid), 0);
        chk("reload_rn", 32'(round_nr), 14);
        wait_done(0, 15, 15, "reload");

        // Asynchronous reset in the middle of MAIN at round 5
        pulse_next(1'b0);
        n = 0;
        while (round_nr !== 4'd5 && n < 30) begin
            step();
            n++;
        end
        chk("reach_rn5", 32'(round_nr), 5);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_ready", 32'(ready), 1);
        chk("async_rst_valid", 32'(valid), 0);
        chk("async_rst_rn", 32'(round_nr), 0);
        chk("async_rst_we", 32'(state_we), 0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(ready), 1);
        chk("post_rst_rn", 32'(round_nr), 0);
        pulse_next(1'b0);
        wait_done(0, 11, 11, "post_rst");

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            next      = ($urandom_range(0, 7) == 0);
            keylen    = 1'($urandom_range(0, 1));
            key_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        next      = 1'b0;
        key_ready = 1'b1;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
